// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers
// for the 2R1W scoreboarded register file.
package regfile_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_ADDR  = 0;

    // True when addr names the hardwired zero register.
    function automatic logic is_zero_addr(
        input logic [31:0] addr,
        input int          zero_reg
    );
        return (zero_reg != 0) && (addr == ZERO_ADDR);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one registered read port
// with write bypass, zero register and hold.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] mem [2**ADDR_W],
    input  logic [2**ADDR_W-1:0] pending,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              resv_en,
    input  logic [ADDR_W-1:0] resv_addr,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy
);

    logic              rd_zero;
    logic              wr_hit;
    logic              rsv_hit;
    logic [DATA_W-1:0] data_nxt;
    logic              busy_nxt;

    // Select array, forwarded write or zero for this read.
    always_comb begin
        rd_zero  = is_zero_addr(32'(raddr), ZERO_REG);
        wr_hit   = (BYPASS != 0) && we
                 && (waddr == raddr) && !rd_zero;
        rsv_hit  = resv_en && (resv_addr == raddr)
                 && !rd_zero;
        data_nxt = mem[raddr];
        busy_nxt = pending[raddr];
        unique case (1'b1)
            rd_zero: begin
                data_nxt = '0;
                busy_nxt = 1'b0;
            end
            wr_hit: begin
                data_nxt = wdata;
                busy_nxt = rsv_hit;
            end
            default: ;
        endcase
    end

    // Registered outputs; data and busy hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
            busy   <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                rdata <= data_nxt;
                busy  <= busy_nxt;
            end
        end
    end

endmodule

// File: rtl/regfile_2r1w_sb.sv
// regfile_2r1w_sb: 2-read 1-write register file
// with per-register pending bits and a count.
module regfile_2r1w_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              resv_en,
    input  logic [ADDR_W-1:0] resv_addr,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    output logic              busy_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b,
    output logic              busy_b,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pend_nxt;
    logic              w_ok;
    logic              r_ok;
    logic              inc;
    logic              dec;

    // Qualify write/reservation and derive count deltas.
    always_comb begin
        w_ok = we
            && !is_zero_addr(32'(waddr), ZERO_REG);
        r_ok = resv_en
            && !is_zero_addr(32'(resv_addr), ZERO_REG);
        inc  = r_ok && !pending[resv_addr];
        dec  = w_ok && pending[waddr]
            && !(r_ok && (resv_addr == waddr));
        pend_nxt = pending;
        if (w_ok) pend_nxt[waddr] = 1'b0;
        if (r_ok) pend_nxt[resv_addr] = 1'b1;
    end

    // Register storage; cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (w_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // Pending bits: reservation wins over writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pend_nxt;
    end

    // Incrementally tracked population count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_cnt <= '0;
        end else begin
            pending_cnt <= pending_cnt
                         + (ADDR_W+1)'(inc)
                         - (ADDR_W+1)'(dec);
        end
    end

    regfile_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_port_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem      (mem),
        .pending  (pending),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .resv_en  (resv_en),
        .resv_addr(resv_addr),
        .re       (re_a),
        .raddr    (raddr_a),
        .rdata    (rdata_a),
        .rvalid   (rvalid_a),
        .busy     (busy_a)
    );

    regfile_read_port #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_port_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .mem      (mem),
        .pending  (pending),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .resv_en  (resv_en),
        .resv_addr(resv_addr),
        .re       (re_b),
        .raddr    (raddr_b),
        .rdata    (rdata_b),
        .rvalid   (rvalid_b),
        .busy     (busy_b)
    );

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
- Parametrised register file with 2 read ports and 1 write port for the datapath's operand fetch stage.
- Extends the existing 32x64 register storage in four ways:
  - asynchronous active-low reset;
  - independent read and write in the same cycle;
  - write-to-read bypass;
  - a per-register pending (scoreboard) bit.
- The pending bit lets the issue logic detect operands whose producer has not yet written back.
- Sits between the decode/issue stage and the writeback bus.

Parameters:
- DATA_W, 64, width of each register in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- ZERO_REG, 1, if 1, register 0 is hardwired: reads 0, never pending, writes and reservations to it are ignored.
- BYPASS, 1, if 1, a same-cycle write to the register being read is forwarded to the read data.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- resv_en  in  1  mark register resv_addr pending (issue of an instruction that will write it).
- resv_addr  in  ADDR_W  register to reserve.
- re_a  in  1  read enable, port A.
- raddr_a  in  ADDR_W  read address, port A.
- rdata_a  out  DATA_W  registered read data, port A.
- rvalid_a  out  1  rdata_a/busy_a updated this cycle.
- busy_a  out  1  register read on port A was pending.
- re_b, raddr_b, rdata_b, rvalid_b, busy_b: identical, port B.
- pending_cnt  out  ADDR_W+1  number of registers currently pending.

Behaviour:
- Reset (rst_n low, asynchronous): all registers = 0, all pending bits = 0, rdata_x = 0, rvalid_x = 0, busy_x = 0, pending_cnt = 0.
  - Reset asserted mid-operation discards any in-flight write or reservation.
  - First edge after deassertion behaves normally.
- Write: at edge with we=1, mem[waddr] <= wdata.
  - If ZERO_REG=1 and waddr=0, no effect.
  - A write always clears pending[waddr].
- Reservation: at edge with resv_en=1, pending[resv_addr] <= 1.
  - Ignored for address 0 when ZERO_REG=1.
  - Reserving an already-pending register keeps it pending, with no count change.
- Simultaneous write and reservation to the same address: reservation wins; data is written and the bit stays pending (new producer issued).
  - pending_cnt is unchanged in that case.
- Write without a prior reservation is legal; data is written and the count is unchanged.
- Read latency is 1 cycle. At edge with re_x=1:
  - rdata_x <= mem[raddr_x]; busy_x <= pending[raddr_x]; rvalid_x <= 1.
  - If BYPASS=1, we=1 and waddr=raddr_x (non-zero if ZERO_REG), rdata_x <= wdata and busy_x <= 0, unless resv_en=1 with resv_addr=raddr_x, in which case busy_x <= 1.
  - If BYPASS=0, a same-address read returns the old contents and the old pending bit.
  - Address 0 with ZERO_REG=1: rdata_x <= 0, busy_x <= 0.
- When re_x=0: rdata_x and busy_x hold their previous values; rvalid_x <= 0.
- Ports A and B are fully independent. Both may read the same address, and both may coincide with a write.
- pending_cnt: registered, equal to the population count of the pending bits after each edge.
  - Updated incrementally: +1 on a reservation of a non-pending register; -1 on a write clearing a pending register with no same-address reservation.
  - Maximum value 2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG), no wrap possible.
- No X propagation: unwritten registers read 0 after reset.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W constants;
  - ZERO_ADDR = 0;
  - a function is_zero_addr(addr, ZERO_REG) shared by the write, reservation and read paths.
- Sub-module regfile_read_port, instantiated twice: takes the array/pending vector plus the write and reservation buses, and implements bypass, zero-register and hold logic with its registered outputs.
- Storage, pending vector and counter live in the top.

Test Plan:
- Reset then read: rst_n low 2 cycles, re_a=1 raddr_a=7 -> next cycle rdata_a=0, busy_a=0, rvalid_a=1, pending_cnt=0.
- Write/read with bypass: we=1 waddr=3 wdata=0xDEADBEEF_00000001 with re_a=1 raddr_a=3 in the same cycle -> next cycle rdata_a=0xDEADBEEF_00000001 (BYPASS=1). With BYPASS=0, the same stimulus gives rdata_a=0.
- Zero register: we=1 waddr=0 wdata=0x55, then re_b raddr_b=0 -> rdata_b=0. resv_en resv_addr=0 -> pending_cnt stays 0.
- Scoreboard: resv_en addr=9 -> pending_cnt=1; read 9 -> busy=1; write 9 data=42 -> pending_cnt=0; read 9 -> rdata=42, busy=0.
- Simultaneous reserve and write to addr 9 while pending -> pending_cnt stays 1; a subsequent read 9 gives busy=1 and rdata equal to the new data.
- Async reset mid-op: reserve 4 registers, assert rst_n between edges -> outputs and pending_cnt go to 0 immediately, without waiting for a clock edge. A write on the edge concurrent with reset is lost.
